binary_bram_reader: RTL and testbench
=====================================

Name: binary_bram_reader

Overview:
- Read-side companion to the binary frame capture BRAM.
- After a frame has been captured as 1-bit pixels, this block scans the BRAM in raster order through its registered read port (1-cycle latency).
- It re-expands each bit to an 8-bit pixel (0 or 255) and emits it on a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers.
- Consumers are downstream pattern-recognition stages; backpressure is absorbed by an internal 2-entry skid FIFO.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=2).
- IMG_HEIGHT, 480, lines per frame (>=1).
- NPIX (localparam), IMG_WIDTH*IMG_HEIGHT, pixels per frame.
- ADDR_W (localparam), $clog2(NPIX), BRAM address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begin scanning a frame (tie to capture_complete).
- rd_en  out  1  BRAM read enable; high only in cycles that issue an address.
- rd_addr  out  ADDR_W  BRAM read address.
- rd_data  in  1  BRAM registered read data; valid the cycle after rd_en.
- y_valid  out  1  output pixel valid.
- y_ready  in  1  downstream ready.
- y_data  out  8  pixel: 8'd255 if bit=1, else 8'd0.
- y_sop  out  1  qualifies y_data as pixel 0 of the frame.
- y_eol  out  1  qualifies y_data as the last pixel of a line.
- y_eop  out  1  qualifies y_data as pixel NPIX-1.
- busy  out  1  high from start acceptance until the last pixel handshakes.
- done  out  1  one-cycle pulse the cycle after the last pixel handshake.

Behaviour:
- Reset values (rst high at an edge):
  - Outputs: rd_en=0, rd_addr=0, y_valid=0, y_data=0, y_sop/y_eol/y_eop=0, busy=0, done=0.
  - Internal: FIFO emptied, in-flight flag cleared, state=IDLE.
- Reset mid-frame aborts the scan immediately. No done pulse. Pixels not yet delivered are discarded.
- State machine: IDLE -> READ -> DRAIN -> IDLE.
  - IDLE:
    - start=1 -> READ; busy=1; issue counter=0.
    - start in any other state is ignored.
  - READ:
    - Issue rule: issue when (fifo_count + inflight - pop) < 2, where pop = y_valid && y_ready in the same cycle.
    - On issue: rd_en=1, rd_addr=issue counter, counter increments.
    - After issuing address NPIX-1 -> DRAIN.
  - DRAIN:
    - No further issues.
    - When FIFO is empty and nothing is in flight (last pixel handshaken): busy=0, done=1 for one cycle -> IDLE.
- Read pipeline:
  - rd_data sampled into the FIFO on the edge after the issue cycle (inflight=1 during that window).
  - FIFO entry holds {data, sop, eol, eop} computed from the issued address:
    - sop = (addr==0)
    - eol = (column==IMG_WIDTH-1)
    - eop = (addr==NPIX-1)
  - Column tracking uses a separate column counter. No divider.
- Latency: start sampled at edge E0 -> rd_en/rd_addr=0 during the cycle after E0 -> y_valid high after edge E2 (2 edges after start).
- Throughput: 1 pixel/clk with y_ready held high. The FIFO never overflows. rd_en is never asserted when no FIFO slot would be free.
- Stream rules:
  - Once y_valid=1, y_data and the markers are held stable until handshake.
  - y_valid is never deasserted without a handshake, except on rst.
  - Markers are meaningful only while y_valid=1 and are 0 otherwise.
- Simultaneous push and pop with FIFO full is legal; occupancy stays constant.
- Address wrap: the counter stops at NPIX-1 and never wraps within a frame. The next start restarts at 0.
- start coincident with the done cycle is ignored (state is still DRAIN). A new frame needs start while in IDLE.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, NPIX=12; BRAM model with 1-cycle registered read):
- Reset: hold rst 2 cycles mid-idle -> all outputs 0; the FIFO empty check passes.
- Full-rate scan: pattern 101100111000, y_ready=1, start pulse -> y_valid rises 2 edges after start.
  - y_data sequence 255,0,255,255,0,0,255,255,255,0,0,0 on 12 consecutive cycles.
  - y_sop on pixel 0; y_eol on pixels 3, 7, 11; y_eop on pixel 11.
  - done pulses 1 cycle after pixel 11; busy low the same cycle.
- Backpressure: y_ready toggles 1,0,0,1,... randomly -> the same 12 values in order, none lost or duplicated.
  - Held values stay stable while y_ready=0.
  - rd_en never causes more than 2 pixels outstanding.
- y_ready=0 for 20 cycles after start -> exactly 2 rd_en pulses (addrs 0, 1), y_valid=1 with y_data of pixel 0 stable.
  - Releasing y_ready resumes at pixel 1.
- start pulses while busy (e.g. at pixels 5 and 11) -> ignored; exactly 12 pixels and one done.
  - A second start after done -> a fresh frame starting at addr 0 with y_sop.
- rst asserted after pixel 6 handshakes -> next cycle y_valid=0, busy=0, no done.
  - A new start yields a complete frame from pixel 0.

Source files
------------

// File: rtl/binary_bram_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : binary_bram_reader_if
//  Brief    : BRAM read port and pixel stream bundle for binary_bram_reader.
//             The master is the reader. The slave is the BRAM plus the
//             downstream consumer.
//  Revision : 1.0 - initial release
// ============================================================================
interface binary_bram_reader_if #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
);
    localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_W = $clog2(NPIX);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic              y_valid;
    logic              y_ready;
    logic [7:0]        y_data;
    logic              y_sop;
    logic              y_eol;
    logic              y_eop;

    modport master (
        output rd_en, rd_addr, y_valid, y_data, y_sop, y_eol, y_eop,
        input  rd_data, y_ready
    );

    modport slave (
        input  rd_en, rd_addr, y_valid, y_data, y_sop, y_eol, y_eop,
        output rd_data, y_ready
    );
endinterface
`default_nettype wire

// File: rtl/binary_bram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : binary_bram_reader
//  Brief    : Scans a 1-bit frame BRAM in raster order. Each bit is expanded
//             to an 8-bit pixel (0/255) and sent out on a valid/ready stream
//             with sop/eol/eop markers. A 2-entry FIFO absorbs backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module binary_bram_reader #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  start,
    binary_bram_reader_if.master bus,
    output logic                 busy,
    output logic                 done
);
    localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int COL_W  = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  c_last_col  = COL_W'(IMG_WIDTH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [COL_W-1:0]  r_col;
    logic              r_inflight;
    logic [2:0]        r_meta;      // {sop, eol, eop} of the read in flight
    logic [3:0]        r_mem [2];   // {data, sop, eol, eop}
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              r_busy;
    logic              r_done;

    logic       w_valid;
    logic [3:0] w_head;
    logic       w_pop;
    logic [2:0] w_occ;
    logic       w_issue;

    assign w_valid = (r_count != 2'd0);
    assign w_head  = r_mem[r_rptr];
    assign w_pop   = w_valid && bus.y_ready;
    // Slots already committed: the stored entries plus the read in flight.
    // A pop in this cycle frees one slot in time for this cycle's issue.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_issue = (r_state == c_st_read) && (w_occ < (3'd2 + {2'b00, w_pop}));

    assign bus.rd_en   = w_issue;
    assign bus.rd_addr = r_addr;
    assign bus.y_valid = w_valid;
    assign bus.y_data  = (w_valid && w_head[3]) ? 8'hFF : 8'h00;
    assign bus.y_sop   = w_valid && w_head[2];
    assign bus.y_eol   = w_valid && w_head[1];
    assign bus.y_eop   = w_valid && w_head[0];
    assign busy        = r_busy;
    assign done        = r_done;

    // Scan control: FSM, address/column counters, in-flight tag, busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_col      <= '0;
            r_inflight <= 1'b0;
            r_meta     <= 3'b000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_meta <= {(r_addr == '0), (r_col == c_last_col), (r_addr == c_last_addr)};
            end
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_read;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_col   <= '0;
                    end
                end
                c_st_read: begin
                    if (w_issue) begin
                        // The counter holds at the last address and never wraps.
                        if (r_addr == c_last_addr) begin
                            r_state <= c_st_drain;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                        r_col <= (r_col == c_last_col) ? '0 : r_col + COL_W'(1);
                    end
                end
                c_st_drain: begin
                    // Stay in DRAIN through the done cycle so a start there is ignored.
                    if (r_done) begin
                        r_state <= c_st_idle;
                    end else if (w_pop && w_head[0]) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Two-entry skid FIFO. It is filled from BRAM data one cycle after issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_mem[0] <= 4'h0;
            r_mem[1] <= 4'h0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wptr] <= {bus.rd_data, r_meta};
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_binary_bram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_binary_bram_reader
//  Brief    : Self-checking bench for binary_bram_reader (4x3 frame) with a
//             1-cycle registered BRAM model and a stream reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_binary_bram_reader;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    typedef struct {
        bit ready;
        bit rd_en;
        int addr;
        bit valid;
        int data;
        bit sop;
        bit eol;
        bit eop;
        bit busy;
        bit done;
    } vec_t;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;

    binary_bram_reader_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    binary_bram_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    logic [NPIX-1:0] pat;
    int exp_pix [NPIX] = '{255, 0, 255, 255, 0, 0, 255, 255, 255, 0, 0, 0};
    vec_t tbl [16];

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    int frame_gen = 0;

    // stream reference model state
    int m_gen      = 0;
    int m_idx      = 0;
    int m_iss      = 0;
    bit m_stall    = 0;
    bit m_eop_prev = 0;
    int m_pdata    = 0;
    bit m_psop     = 0;
    bit m_peol     = 0;
    bit m_peop     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model: registered read, one cycle latency
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= pat[bus.rd_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit accepted);
        start = 1'b1;
        if (accepted) frame_gen++;
        step();
        start = 1'b0;
    endtask

    task automatic monitor_step();
        bit hs;
        if (rst) begin
            m_idx = 0; m_iss = 0; m_stall = 0; m_eop_prev = 0;
            return;
        end
        if (frame_gen != m_gen) begin
            m_gen = frame_gen; m_idx = 0; m_iss = 0; m_stall = 0; m_eop_prev = 0;
        end
        chk("done_timing", done, m_eop_prev);
        if (m_eop_prev) chk("busy_at_done", busy, 0);
        if (done) n_done++;
        m_eop_prev = 0;
        if (m_stall) begin
            chk("hold_valid", bus.y_valid, 1);
            chk("hold_data", bus.y_data, m_pdata);
            chk("hold_marks", {bus.y_sop, bus.y_eol, bus.y_eop}, {m_psop, m_peol, m_peop});
        end
        if (bus.rd_en) begin
            chk("issue_in_range", int'(m_iss < NPIX), 1);
            chk("rd_addr", bus.rd_addr, m_iss);
            m_iss++;
        end
        hs = bus.y_valid && bus.y_ready;
        if (hs) begin
            if (m_idx >= NPIX) begin
                chk("extra_pixel", m_idx, NPIX - 1);
            end else begin
                chk("pix_data", bus.y_data, pat[m_idx] ? 255 : 0);
                chk("pix_sop", bus.y_sop, int'(m_idx == 0));
                chk("pix_eol", bus.y_eol, int'((m_idx % W) == W - 1));
                chk("pix_eop", bus.y_eop, int'(m_idx == NPIX - 1));
                if (m_idx == NPIX - 1) m_eop_prev = 1;
            end
            m_idx++;
        end
        if (bus.rd_en) chk("outstanding_le2", int'((m_iss - m_idx) <= 2), 1);
        if (!bus.y_valid) chk("idle_marks", {bus.y_data, bus.y_sop, bus.y_eol, bus.y_eop}, 0);
        m_stall = bus.y_valid && !bus.y_ready;
        m_pdata = bus.y_data;
        m_psop  = bus.y_sop;
        m_peol  = bus.y_eol;
        m_peop  = bus.y_eop;
    endtask

    // mode 1: random ready, mode 2: ready held high
    task automatic run_until_done(input int mode, input int budget, input string name);
        int d0;
        int c;
        d0 = n_done;
        c  = 0;
        while (n_done == d0 && c < budget) begin
            if (mode == 1) bus.y_ready = 1'($urandom_range(0, 1));
            else bus.y_ready = 1'b1;
            step();
            c++;
        end
        chk(name, n_done - d0, 1);
        chk("pix_count", m_idx, NPIX);
    endtask

    initial begin
        int n_rd;
        int d0;

        for (int k = 0; k < 16; k++) begin
            tbl[k].ready = 1'b1;
            tbl[k].rd_en = (k < NPIX);
            tbl[k].addr  = k;
            tbl[k].valid = (k >= 2 && k <= 13);
            tbl[k].data  = tbl[k].valid ? exp_pix[k-2] : 0;
            tbl[k].sop   = (k == 2);
            tbl[k].eol   = (k == 5 || k == 9 || k == 13);
            tbl[k].eop   = (k == 13);
            tbl[k].busy  = (k <= 13);
            tbl[k].done  = (k == 14);
        end

        rst = 1'b1; start = 1'b0; bus.y_ready = 1'b0;
        pat = 12'b000111001101;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // reset, then a second reset held 2 cycles while idle
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_valid", bus.y_valid, 0);
        chk("rst_data", bus.y_data, 0);
        chk("rst_marks", {bus.y_sop, bus.y_eol, bus.y_eop}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // full-rate scan, cycle by cycle against the table
        step();
        bus.y_ready = 1'b1;
        pulse_start(1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            bus.y_ready = tbl[k].ready;
            @(negedge clk);
            chk("tbl_rd_en", bus.rd_en, tbl[k].rd_en);
            if (tbl[k].rd_en) chk("tbl_rd_addr", bus.rd_addr, tbl[k].addr);
            chk("tbl_valid", bus.y_valid, tbl[k].valid);
            chk("tbl_data", bus.y_data, tbl[k].data);
            chk("tbl_sop", bus.y_sop, tbl[k].sop);
            chk("tbl_eol", bus.y_eol, tbl[k].eol);
            chk("tbl_eop", bus.y_eop, tbl[k].eop);
            chk("tbl_busy", busy, tbl[k].busy);
            chk("tbl_done", done, tbl[k].done);
        end
        step();

        // random backpressure
        pulse_start(1);
        run_until_done(1, 300, "bp_frame_done");
        step();

        // ready low for 20 cycles after start
        bus.y_ready = 1'b0;
        pulse_start(1);
        n_rd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rd_en) n_rd++;
            step();
        end
        @(negedge clk);
        chk("stall_rd_pulses", n_rd, 2);
        chk("stall_valid", bus.y_valid, 1);
        chk("stall_data", bus.y_data, 255);
        chk("stall_sop", bus.y_sop, 1);
        step();
        run_until_done(2, 100, "stall_frame_done");
        step();

        // start pulses while busy (pixel 5, pixel 11, done cycle) are ignored
        d0 = n_done;
        bus.y_ready = 1'b1;
        pulse_start(1);
        for (int k = 0; k < 21; k++) begin
            start = (k == 7 || k == 13 || k == 14);
            step();
        end
        start = 1'b0;
        chk("ign_one_done", n_done - d0, 1);
        chk("ign_pix_count", m_idx, NPIX);
        chk("ign_busy_low", busy, 0);
        pulse_start(1);
        run_until_done(2, 100, "restart_frame_done");
        step();

        // reset after pixel 6 handshakes
        d0 = n_done;
        pulse_start(1);
        repeat (9) step();
        chk("pre_rst_pixels", m_idx, 7);
        rst = 1'b1;
        bus.y_ready = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", bus.y_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_en", bus.rd_en, 0);
        step();
        repeat (5) step();
        chk("abort_no_done", n_done - d0, 0);
        bus.y_ready = 1'b1;
        pulse_start(1);
        run_until_done(2, 100, "post_rst_frame_done");
        step();

        // random patterns with random backpressure
        for (int f = 0; f < 4; f++) begin
            pat = NPIX'($urandom);
            pulse_start(1);
            run_until_done(1, 300, "rand_frame_done");
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
